// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline MEM stage and the data memory responder.
// Signal names follow the pipeline's existing data-memory port names.
interface data_mem_responder_if;
  logic        reqValid;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic        busy;

  modport master (
    output reqValid, reqWrite, reqAddr, reqWData,
    input  reqReady, rspValid, rspData, rspErr, busy
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWData,
    output reqReady, rspValid, rspData, rspErr, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder with programmable wait states.
// One access in flight at a time: IDLE accepts, WAIT counts down, RESP pulses rspValid.
// Optional feature: define DATA_MEM_RESP_WBUF_EN to add a one-entry posted write buffer
// that lets non-faulting writes respond in one cycle and drain to the array later.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              req_err;
  logic [IdxW-1:0]   req_idx;
  logic              enter_resp;
  logic [31:0]       rd_word;
  logic              mem_we;
  logic [IdxW-1:0]   mem_widx;
  logic [31:0]       mem_wdata;

`ifdef DATA_MEM_RESP_WBUF_EN
  logic              wb_valid_q, wb_valid_d;
  logic [IdxW-1:0]   wb_idx_q, wb_idx_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_cnt_q, wb_cnt_d;
  logic              wb_load;
  logic              wb_drain;
`else
  logic [31:0]       wdata_q, wdata_d;
`endif

  assign req_idx = bus.reqAddr[IdxW+1:2];
  // Misaligned or beyond the array: the access faults and never touches memory.
  assign req_err = (bus.reqAddr[1:0] != 2'b00) || ({2'b00, bus.reqAddr[31:2]} >= DEPTH_WORDS);
  assign accept  = bus.reqValid && bus.reqReady;

  // Output decode from the current state.
  always_comb begin
    bus.reqReady = (state_q == StIdle);
`ifdef DATA_MEM_RESP_WBUF_EN
    // Only reads may enter while a posted write is still pending.
    if (wb_valid_q && bus.reqWrite) begin
      bus.reqReady = 1'b0;
    end
`endif
    bus.rspValid = (state_q == StResp);
    bus.busy     = ((state_q == StIdle) && bus.reqValid) || (state_q == StWait);
    bus.rspData  = rsp_data_q;
    bus.rspErr   = rsp_err_q;
  end

  // Next-state and request latching; read data is captured on entry to RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rd_word    = 32'h0;
`ifdef DATA_MEM_RESP_WBUF_EN
    wb_load    = 1'b0;
`else
    wdata_d    = wdata_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = req_idx;
          write_d = bus.reqWrite;
          err_d   = req_err;
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
`ifdef DATA_MEM_RESP_WBUF_EN
          if (bus.reqWrite && !req_err) begin
            wb_load = 1'b1;
            state_d = StResp;
          end
`else
          wdata_d = bus.reqWData;
`endif
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    enter_resp = (state_d == StResp) && (state_q != StResp);
    rd_word    = mem[idx_d];
`ifdef DATA_MEM_RESP_WBUF_EN
    if (wb_valid_q && (wb_idx_q == idx_d)) begin
      rd_word = wb_data_q;
    end
`endif
    if (enter_resp) begin
      rsp_err_d  = err_d;
      rsp_data_d = (write_d || err_d) ? 32'h0 : rd_word;
    end
  end

`ifdef DATA_MEM_RESP_WBUF_EN
  // Posted write buffer: loads on accept, drains WAIT_CYCLES+1 cycles later.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    wb_cnt_d   = wb_cnt_q;
    wb_drain   = wb_valid_q && (wb_cnt_q == 5'd1);
    if (wb_valid_q) begin
      wb_cnt_d = wb_cnt_q - 5'd1;
      if (wb_drain) begin
        wb_valid_d = 1'b0;
      end
    end
    if (wb_load) begin
      wb_valid_d = 1'b1;
      wb_idx_d   = req_idx;
      wb_data_d  = bus.reqWData;
      wb_cnt_d   = 5'(WAIT_CYCLES) + 5'd1;
    end
  end

  // Buffer state; reset drops any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= 32'h0;
      wb_cnt_q   <= 5'd0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // Array write port is owned by the buffer drain.
  always_comb begin
    mem_we    = wb_drain;
    mem_widx  = wb_idx_q;
    mem_wdata = wb_data_q;
  end
`else
  // Write commits on the edge leaving RESP; faulting writes are dropped.
  always_comb begin
    mem_we    = (state_q == StResp) && write_q && !err_q;
    mem_widx  = idx_q;
    mem_wdata = wdata_q;
  end

  // Latched write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata_q <= 32'h0;
    end else begin
      wdata_q <= wdata_d;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage array; contents survive reset. mem_we is gated by the async-reset state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a randomized
// sequence checked against a word-level memory model.
module tb_data_mem_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Wait  = 2;
`ifdef DATA_MEM_RESP_WBUF_EN
  localparam bit WBuf = 1'b1;
`else
  localparam bit WBuf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [31:0] model_mem [int unsigned];

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(Wait)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  data_mem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  // One access on the WAIT_CYCLES=2 instance. Starts and ends 1 time unit after a rising edge.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int wait_n, output int lat, output logic [31:0] data,
                        output logic err);
    wait_n = 0;
    lat    = 0;
    data   = 32'hx;
    err    = 1'bx;
    bus2.reqValid = 1'b1;
    bus2.reqWrite = wr;
    bus2.reqAddr  = addr;
    bus2.reqWData = wdata;
    #1;
    while (bus2.reqReady !== 1'b1 && wait_n < 40) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (bus2.reqReady !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL accept_timeout: reqReady=%b after %0d cycles, required 1", bus2.reqReady,
               wait_n);
      bus2.reqValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus2.reqValid = 1'b0;
    lat = 1;
    while (bus2.rspValid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus2.rspData;
    err  = bus2.rspErr;
    @(posedge clk); #1;
  endtask

  function automatic int exp_lat(input logic wr, input logic err);
    return (WBuf && wr && !err) ? 1 : 1 + int'(Wait);
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus2.reqValid = 1'b1; bus2.reqWrite = 1'b1;
    bus2.reqAddr = 32'h10; bus2.reqWData = 32'h1;
    bus0.reqValid = 1'b0; bus0.reqWrite = 1'b0;
    bus0.reqAddr = 32'h0; bus0.reqWData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus2.reqReady !== 1'b1) begin n_mis++;
      $display("FAIL rst_ready: got %b need 1", bus2.reqReady); end
    n_cmp++; if (bus2.rspValid !== 1'b0) begin n_mis++;
      $display("FAIL rst_rspvalid: got %b need 0", bus2.rspValid); end
    n_cmp++; if (bus2.rspData !== 32'h0) begin n_mis++;
      $display("FAIL rst_rspdata: got %h need 0", bus2.rspData); end
    n_cmp++; if (bus2.rspErr !== 1'b0) begin n_mis++;
      $display("FAIL rst_rsperr: got %b need 0", bus2.rspErr); end
    n_cmp++; if (bus2.busy !== 1'b1) begin n_mis++;
      $display("FAIL rst_busy_hi: got %b need 1", bus2.busy); end
    bus2.reqValid = 1'b0;
    #1;
    n_cmp++; if (bus2.busy !== 1'b0) begin n_mis++;
      $display("FAIL rst_busy_lo: got %b need 0", bus2.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int w, l; logic [31:0] d; logic e;
    access(1'b1, 32'h10, 32'hDEADBEEF, w, l, d, e);
    model_mem[4] = 32'hDEADBEEF;
    n_cmp++; if (l != exp_lat(1'b1, 1'b0)) begin n_mis++;
      $display("FAIL wr_latency: got %0d need %0d", l, exp_lat(1'b1, 1'b0)); end
    n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_mis++;
      $display("FAIL wr_rsp: data %h err %b need 0/0", d, e); end
    access(1'b0, 32'h10, 32'h0, w, l, d, e);
    n_cmp++; if (l != 3) begin n_mis++;
      $display("FAIL rd_latency: got %0d need 3", l); end
    n_cmp++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_mis++;
      $display("FAIL rd_data: data %h err %b need deadbeef/0", d, e); end
  endtask

  task automatic test_faults();
    int w, l; logic [31:0] d; logic e;
    access(1'b1, 32'h0, 32'h0BADF00D, w, l, d, e);
    model_mem[0] = 32'h0BADF00D;
    access(1'b0, 32'h13, 32'h0, w, l, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_mis++;
      $display("FAIL misaligned_rd: err %b data %h need 1/0", e, d); end
    access(1'b1, 4 * Depth, 32'hFFFFFFFF, w, l, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_mis++;
      $display("FAIL range_wr: err %b data %h need 1/0", e, d); end
    n_cmp++; if (l != 1 + int'(Wait)) begin n_mis++;
      $display("FAIL range_wr_latency: got %0d need %0d", l, 1 + Wait); end
    access(1'b0, 32'h0, 32'h0, w, l, d, e);
    n_cmp++; if (d !== 32'h0BADF00D || e !== 1'b0) begin n_mis++;
      $display("FAIL word0_intact: data %h err %b need 0badf00d/0", d, e); end
  endtask

  // WAIT_CYCLES=0 instance with reqValid held: accept on even cycles, respond on odd.
  task automatic test_back_to_back();
    logic acc;
    bus0.reqValid = 1'b1; bus0.reqWrite = 1'b0; bus0.reqAddr = 32'h8;
    for (int i = 0; i < 6; i++) begin
      #1;
      acc = bus0.reqValid & bus0.reqReady;
      n_cmp++; if (acc !== ((i % 2) == 0)) begin n_mis++;
        $display("FAIL b2b_accept cyc %0d: got %b need %b", i, acc, (i % 2) == 0); end
      n_cmp++; if (bus0.rspValid !== ((i % 2) == 1)) begin n_mis++;
        $display("FAIL b2b_rspvalid cyc %0d: got %b need %b", i, bus0.rspValid, (i % 2) == 1); end
      n_cmp++; if (bus0.busy !== ((i % 2) == 0)) begin n_mis++;
        $display("FAIL b2b_busy cyc %0d: got %b need %b", i, bus0.busy, (i % 2) == 0); end
      @(posedge clk); #1;
    end
    bus0.reqValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int w, l; logic [31:0] d; logic e;
    access(1'b1, 32'h20, 32'h12345678, w, l, d, e);
    model_mem[8] = 32'h12345678;
    repeat (Wait + 2) @(posedge clk);
    #1;
    bus2.reqValid = 1'b1; bus2.reqWrite = 1'b1;
    bus2.reqAddr = 32'h20; bus2.reqWData = 32'h55;
    @(posedge clk); #1;
    bus2.reqValid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus2.rspValid !== 1'b0 || bus2.reqReady !== 1'b1) begin n_mis++;
      $display("FAIL midrst_outputs: rspValid %b reqReady %b need 0/1", bus2.rspValid,
               bus2.reqReady); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus2.rspValid !== 1'b0) begin n_mis++;
        $display("FAIL midrst_no_rsp cyc %0d: got %b need 0", i, bus2.rspValid); end
    end
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 32'h20, 32'h0, w, l, d, e);
    n_cmp++; if (d !== 32'h12345678 || e !== 1'b0) begin n_mis++;
      $display("FAIL midrst_old_data: data %h err %b need 12345678/0", d, e); end
  endtask

`ifdef DATA_MEM_RESP_WBUF_EN
  task automatic test_wbuf();
    int w, l; logic [31:0] d; logic e;
    access(1'b1, 32'h40, 32'hA5A5A5A5, w, l, d, e);
    model_mem[16] = 32'hA5A5A5A5;
    n_cmp++; if (l != 1) begin n_mis++;
      $display("FAIL wbuf_wr_latency: got %0d need 1", l); end
    access(1'b0, 32'h40, 32'h0, w, l, d, e);
    n_cmp++; if (d !== 32'hA5A5A5A5) begin n_mis++;
      $display("FAIL wbuf_rd: got %h need a5a5a5a5", d); end
    access(1'b1, 32'h44, 32'h11112222, w, l, d, e);
    model_mem[17] = 32'h11112222;
    bus2.reqValid = 1'b1; bus2.reqWrite = 1'b1; bus2.reqAddr = 32'h48;
    bus2.reqWData = 32'h33334444;
    #1;
    n_cmp++; if (bus2.reqReady !== 1'b0) begin n_mis++;
      $display("FAIL wbuf_full_wr_ready: got %b need 0", bus2.reqReady); end
    bus2.reqWrite = 1'b0;
    #1;
    n_cmp++; if (bus2.reqReady !== 1'b1) begin n_mis++;
      $display("FAIL wbuf_full_rd_ready: got %b need 1", bus2.reqReady); end
    access(1'b1, 32'h48, 32'h33334444, w, l, d, e);
    model_mem[18] = 32'h33334444;
    n_cmp++; if (w != int'(Wait)) begin n_mis++;
      $display("FAIL wbuf_stall_cycles: got %0d need %0d", w, Wait); end
    access(1'b0, 32'h44, 32'h0, w, l, d, e);
    n_cmp++; if (d !== 32'h11112222) begin n_mis++;
      $display("FAIL wbuf_drain_data: got %h need 11112222", d); end
  endtask
`endif

  task automatic test_random();
    int w, l, sel, gap;
    logic [31:0] d, addr, wdata, exp_d;
    logic e, wr, exp_e;
    int unsigned idx;
    for (int i = 0; i < 60; i++) begin
      wr    = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 9);
      addr  = 32'((64 + $urandom_range(0, 7)) * 4);
      wdata = $urandom;
      if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = 32'((Depth + $urandom_range(0, 255)) * 4);
      else if (sel == 2) addr = $urandom | 32'h8000_0000;
      idx   = addr / 4;
      exp_e = (addr % 4 != 0) || (idx >= Depth);
      access(wr, addr, wdata, w, l, d, e);
      n_cmp++; if (e !== exp_e) begin n_mis++;
        $display("FAIL rand_err #%0d addr %h: got %b need %b", i, addr, e, exp_e); end
      n_cmp++; if (l != exp_lat(wr, exp_e)) begin n_mis++;
        $display("FAIL rand_lat #%0d: got %0d need %0d", i, l, exp_lat(wr, exp_e)); end
      n_cmp++; if (bus2.rspValid !== 1'b0) begin n_mis++;
        $display("FAIL rand_pulse #%0d: rspValid %b need 0", i, bus2.rspValid); end
      if (wr || exp_e || model_mem.exists(idx)) begin
        exp_d = (wr || exp_e) ? 32'h0 : model_mem[idx];
        n_cmp++; if (d !== exp_d) begin n_mis++;
          $display("FAIL rand_data #%0d addr %h: got %h need %h", i, addr, d, exp_d); end
      end
      if (wr && !exp_e) model_mem[idx] = wdata;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_faults();
    test_back_to_back();
    test_reset_mid();
`ifdef DATA_MEM_RESP_WBUF_EN
    test_wbuf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the pipeline's MEM-stage data accesses.
- Accepts one read or write request at a time over a valid/ready handshake and services it against an internal word-addressed array after a programmable number of wait states.
- Returns a single-cycle response pulse and drives a stall signal the pipeline uses to freeze stages while an access is in flight.
- Replaces the zero-latency combinational data memory when modelling slow memory.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array (power of two).
- `WAIT_CYCLES`, 2: wait states inserted per access, legal range 0..15.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `reqValid` input 1: request present.
- `reqWrite` input 1: 1 = write, 0 = read; sampled with `reqValid`.
- `reqAddr` input 32: byte address; word index = `reqAddr[31:2]`.
- `reqWData` input 32: write data.
- `reqReady` output 1: responder can accept a request this cycle.
- `rspValid` output 1: one-cycle response pulse.
- `rspData` output 32: read data, valid while `rspValid`=1.
- `rspErr` output 1: access fault flag, valid while `rspValid`=1.
- `busy` output 1: pipeline stall request.

## Operation
- **FSM states**
  - IDLE: `reqReady`=1; `reqValid` & `reqReady` at an edge accepts the request.
  - WAIT: counter counts down the wait states.
  - RESP: response cycle.
- **Accept:** latches address, write flag and write data into internal registers; loads the counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
- **WAIT:** counter decrements each cycle; state moves to RESP on the edge where the counter equals 1.
- **RESP:** `rspValid`=1 for exactly one cycle, then IDLE.
  - Responses cannot be back-pressured; there is no response-ready input.
- **Write:** array updated on the edge leaving RESP; `rspData`=0 for writes.
- **Read:** `rspData` = array word at the latched index, registered when entering RESP.
- **Fault:** `rspErr`=1 when `reqAddr[1:0]`≠0 or word index ≥ `DEPTH_WORDS`.
  - On fault, the write is suppressed and `rspData`=0.
- **`busy`** (combinational) = (IDLE & `reqValid`) | WAIT. It is low in RESP so the pipeline advances on the response cycle.
- Request inputs are ignored outside IDLE. The requester must hold them stable until accepted.

## Timing
- **Reset values:** state IDLE, counter 0, `rspValid`=0, `rspData`=0, `rspErr`=0, `reqReady`=1; `busy` follows `reqValid`.
- Array contents are not reset.
- **Reset mid-access:** the access is abandoned, with no array write and no response. Outputs take reset values immediately (asynchronous).
- **Latency:** request accepted in cycle 0 → `rspValid` in cycle 1+`WAIT_CYCLES`.
- **Next accept:** earliest in cycle 2+`WAIT_CYCLES`. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- **Read-after-write to same word:** a read accepted after the write's RESP returns the new data.

## Configuration
- **`DATA_MEM_RESP_WBUF_EN` defined:** adds a one-entry posted write buffer (valid bit, address, data).
  - **Write path:**
    - An accepted, non-faulting write goes IDLE→RESP directly: `rspValid` in cycle 1, independent of `WAIT_CYCLES`.
    - The buffer drains to the array `WAIT_CYCLES`+1 cycles after load, using its own counter.
    - While the buffer is full, `reqReady` = ~`reqWrite`, so only reads are accepted.
  - **Read path:**
    - Reads use normal latency.
    - A read whose word index matches a valid buffer entry returns the buffered data.
  - **Faulting write:** takes the normal wait path and is not buffered.
  - **Reset:** clears the buffer valid bit; the pending write is lost.
- **Macro undefined:** no buffer; behaviour is exactly as in Operation.

## Test plan
- **Reset:** hold `rst`=0 with `reqValid`=1 → `reqReady`=1, `rspValid`=0, `rspData`=0, `busy`=1. Release → first access completes normally.
- **Write/read (`WAIT_CYCLES`=2):** write 0xDEADBEEF to 0x10 → `rspValid` in cycle 3. Read 0x10 accepted in cycle 4 → `rspValid` in cycle 7 with `rspData`=0xDEADBEEF, `rspErr`=0.
- **Faults:**
  - Read 0x13 → `rspErr`=1, `rspData`=0.
  - Write to byte address 4·`DEPTH_WORDS` → `rspErr`=1. A later read of word 0 is unchanged.
- **`WAIT_CYCLES`=0, back-to-back:** `reqValid` held → accepts in cycles 0, 2, 4; `rspValid` in cycles 1, 3, 5; `busy` high in 0, 2, 4 only.
- **Reset mid-access:** assert `rst` in WAIT of a write of 0x55 to 0x20 → no `rspValid`. A subsequent read of 0x20 returns the previously written value.
- **`DATA_MEM_RESP_WBUF_EN`:**
  - Write 0xA5A5A5A5 to 0x40 → `rspValid` in cycle 1.
  - Immediate read of 0x40 → 0xA5A5A5A5.
  - Second write issued before drain → `reqReady`=0 until the buffer empties.
